// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory port between a read-only fetch requester and a
// read/write data requester, with round-robin under contention and a hang watchdog.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err
);

    localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic OwnFetch = 1'b0;
    localparam logic OwnData  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              m_req_q, m_req_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              grant_data;

    // Data wins when it is alone, or when both request and fetch was served last.
    assign grant_data = d_req & (~i_req | (last_grant_q == OwnFetch));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        m_req_d      = m_req_q;
        m_wr_d       = m_wr_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;

        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d      = StBusy;
                    owner_d      = grant_data ? OwnData : OwnFetch;
                    last_grant_d = grant_data ? OwnData : OwnFetch;
                    timer_d      = '0;
                    m_req_d      = 1'b1;
                    if (grant_data) begin
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wr_d    = d_wr;
                    end else begin
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                        m_wr_d    = 1'b0;
                    end
                end
            end
            StBusy: begin
                if (m_ack) begin
                    state_d = StDone;
                    m_req_d = 1'b0;
                    if (owner_q == OwnData) begin
                        d_rdata_d = m_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_done_d  = 1'b1;
                    end
                end else if (timer_q == TimerLast) begin
                    // Abort: the requester still gets its done pulse, with zeroed data.
                    state_d = StDone;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (owner_q == OwnData) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                m_req_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnFetch;
            last_grant_q <= OwnFetch;
            timer_q      <= '0;
            m_req_q      <= 1'b0;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            m_req_q      <= m_req_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory responder plus a scoreboard
// of expected completions checked with immediate assertions.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_done, i_stall, d_done, d_stall;
    logic          m_req, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    // Responder controls (bench-driven) and observations (responder-driven).
    int            ack_lat = 1;
    logic          ack_en = 1'b1;
    int            stray_req = 0;
    int            stray_done = 0;
    int            cnt = 0;
    logic [AW-1:0] ack_addr = '0;
    logic          ack_wr = 1'b0;
    logic [DW-1:0] ack_wdata = '0;

    typedef struct {
        logic          owner;   // 0 fetch, 1 data
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          chk_m;   // a real ack is expected, so check the memory-side capture
        int            busy;
    } exp_t;

    exp_t sb[$];

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_done (i_done),
        .i_stall(i_stall),
        .d_req  (d_req),
        .d_wr   (d_wr),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_done (d_done),
        .d_stall(d_stall),
        .m_req  (m_req),
        .m_wr   (m_wr),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ack  (m_ack),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    // Memory: acks on the ack_lat-th cycle of m_req; can also inject a stray ack.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cnt   = 0;
            m_ack = 1'b0;
        end else if (m_ack) begin
            m_ack = 1'b0;
            cnt   = 0;
        end else if (stray_req != stray_done) begin
            stray_done = stray_req;
            m_rdata    = 32'hBAD0_BAD0;
            m_ack      = 1'b1;
        end else if (m_req && ack_en) begin
            cnt++;
            if (cnt == ack_lat) begin
                m_ack     = 1'b1;
                m_rdata   = model(m_addr);
                ack_addr  = m_addr;
                ack_wr    = m_wr;
                ack_wdata = m_wdata;
                cnt       = 0;
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic owner, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input logic chk_m, input int busy);
        exp_t e;
        e.owner = owner;
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        e.rdata = rdata;
        e.chk_m = chk_m;
        e.busy  = busy;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a done pulse, compare it with the scoreboard head, then step one
    // cycle and confirm the pulse was exactly one cycle wide.
    task automatic wait_done(input string tag, input int busy0);
        int   busy;
        logic got;
        logic prev_ack;
        exp_t e;
        busy     = busy0;
        got      = 1'b0;
        prev_ack = m_ack;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                got = 1'b1;
            end else begin
                if (m_req) busy++;
                prev_ack = m_ack;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_i_done"}, 32'(i_done), 32'(!e.owner));
        check({tag, "_d_done"}, 32'(d_done), 32'(e.owner));
        if (!e.wr) check({tag, "_rdata"}, e.owner ? d_rdata : i_rdata, e.rdata);
        check({tag, "_served_stall"}, 32'(e.owner ? d_stall : i_stall), 32'd0);
        check({tag, "_other_stall"}, 32'(e.owner ? i_stall : d_stall),
              32'(e.owner ? i_req : d_req));
        check({tag, "_busy_cycles"}, 32'(busy), 32'(e.busy));
        if (e.chk_m) begin
            check({tag, "_m_addr"}, ack_addr, e.addr);
            check({tag, "_m_wr"}, 32'(ack_wr), 32'(e.wr));
            if (e.wr) check({tag, "_m_wdata"}, ack_wdata, e.wdata);
            check({tag, "_ack_to_done"}, 32'(prev_ack), 32'd1);
        end
        @(negedge clk);
        check({tag, "_pulse_width"}, 32'(i_done | d_done), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_wr", 32'(m_wr), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_dones", 32'(i_done | d_done), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single fetch, 2-cycle memory.
        ack_lat = 2;
        i_req   = 1'b1;
        i_addr  = 32'h100;
        push(1'b0, 32'h100, 1'b0, '0, 32'hDEADBEEF, 1'b1, 2);
        #1 check("fetch_stall_idle", 32'(i_stall), 32'd1);
        @(negedge clk);
        check("fetch_m_req", 32'(m_req), 32'd1);
        check("fetch_m_addr", m_addr, 32'h100);
        check("fetch_m_wr", 32'(m_wr), 32'd0);
        check("fetch_stall_busy", 32'(i_stall), 32'd1);
        wait_done("fetch", 1);
        i_req = 1'b0;

        // Data write, 1-cycle memory.
        ack_lat = 1;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h12345678;
        push(1'b1, 32'h20, 1'b1, 32'h12345678, '0, 1'b1, 1);
        @(negedge clk);
        check("dwr_m_wr", 32'(m_wr), 32'd1);
        check("dwr_m_wdata", m_wdata, 32'h12345678);
        wait_done("dwr", 1);
        d_req = 1'b0;

        // Data read; requester inputs scrambled while BUSY must not leak through.
        ack_lat = 3;
        d_req   = 1'b1;
        d_wr    = 1'b0;
        d_addr  = 32'h40;
        push(1'b1, 32'h40, 1'b0, '0, model(32'h40), 1'b1, 3);
        @(negedge clk);
        d_addr  = 32'h999;
        d_wr    = 1'b1;
        d_wdata = 32'hFFFF_FFFF;
        wait_done("drd_hold", 1);
        d_req = 1'b0;
        d_wr  = 1'b0;

        // Fetch dropped mid-BUSY still completes once.
        i_req  = 1'b1;
        i_addr = 32'h600;
        push(1'b0, 32'h600, 1'b0, '0, model(32'h600), 1'b1, 3);
        @(negedge clk);
        i_req  = 1'b0;
        i_addr = 32'h700;
        wait_done("idrop", 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idrop_no_regrant", 32'(m_req | i_done), 32'd0);
        end

        // Stray ack in IDLE changes nothing.
        stray_req++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_idle_outs", 32'({m_req, i_done, d_done}), 32'd0);
            check("stray_idle_rdata", i_rdata, model(32'h600));
        end

        // Contention after reset: DATA, FETCH, DATA, FETCH.
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        ack_lat = 1;
        i_req   = 1'b1;
        i_addr  = 32'h44;
        d_req   = 1'b1;
        d_addr  = 32'h88;
        push(1'b1, 32'h88, 1'b0, '0, model(32'h88), 1'b1, 1);
        push(1'b0, 32'h44, 1'b0, '0, model(32'h44), 1'b1, 1);
        push(1'b1, 32'h88, 1'b0, '0, model(32'h88), 1'b1, 1);
        push(1'b0, 32'h44, 1'b0, '0, model(32'h44), 1'b1, 1);
        for (int k = 0; k < 4; k++) wait_done("contend", 0);
        i_req = 1'b0;
        d_req = 1'b0;

        // Ack on the last permitted cycle beats the watchdog.
        ack_lat = TO;
        i_req   = 1'b1;
        i_addr  = 32'h80;
        push(1'b0, 32'h80, 1'b0, '0, model(32'h80), 1'b1, TO);
        wait_done("ackwin", 0);
        check("ackwin_err", 32'(err), 32'd0);
        i_req = 1'b0;

        // Hung memory: watchdog aborts after TIMEOUT BUSY cycles.
        ack_en = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h300;
        push(1'b0, 32'h300, 1'b0, '0, '0, 1'b0, TO);
        wait_done("tmo", 0);
        check("tmo_err", 32'(err), 32'd1);
        i_req   = 1'b0;
        ack_en  = 1'b1;
        ack_lat = 1;
        d_req   = 1'b1;
        d_addr  = 32'h10;
        push(1'b1, 32'h10, 1'b0, '0, model(32'h10), 1'b1, 1);
        wait_done("post_tmo", 0);
        check("err_sticky", 32'(err), 32'd1);
        d_req = 1'b0;

        // Reset mid-BUSY, then a stray ack.
        ack_en = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h500;
        @(negedge clk);
        check("rstbusy_m_req_before", 32'(m_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy_m_req", 32'(m_req), 32'd0);
        check("rstbusy_err", 32'(err), 32'd0);
        check("rstbusy_i_rdata", i_rdata, 32'd0);
        rst   = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        stray_req++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstbusy_quiet", 32'({m_req, i_done, d_done, err}), 32'd0);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
